dp_pipe: RTL

- Parametrised, pipelined successor to the team's Int8/Int16 combinational-plus-register datapath.
- Per transaction it computes d = a+b, e = a+c, g = d>e, z = g ? d : e, f = a*c, x = f-d.
- Two registered stages with a valid/ready handshake on both sides, and selectable signed/unsigned arithmetic.
- Sits between an operand source and a result consumer, either of which may stall.

---
 rtl/dp_pkg.sv | 40 ++++
 rtl/dp_pipe_stage_reg.sv | 37 +++
 rtl/dp_pipe.sv | 106 ++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared constants and helper functions for the dp_pipe datapath.
//   DP_MAX_W     widest operand the helpers handle
//   DP_UNSIGNED / DP_SIGNED  arithmetic mode selectors
//   prod_w()     product / difference width for a given operand width
//   ext_d()      zero- or sign-extension of d to twice its width
//   gt()         d > e, unsigned or two's-complement
package dp_pkg;

  localparam int   DP_MAX_W    = 32;
  localparam logic DP_UNSIGNED = 1'b0;
  localparam logic DP_SIGNED   = 1'b1;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Operand sits in the low w bits; the caller casts the result down to 2*w.
  function automatic logic [2*DP_MAX_W-1:0] ext_d(input logic [DP_MAX_W-1:0] d,
                                                  input int w, input logic sgn);
    logic [2*DP_MAX_W-1:0] r;
    logic                  msb;
    r   = {{DP_MAX_W{1'b0}}, d};
    msb = |(d & (DP_MAX_W'(1) << (w - 1)));
    if (sgn == DP_SIGNED && msb) begin
      for (int i = 0; i < 2*DP_MAX_W; i++) begin
        if (i >= w) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic gt(input logic [DP_MAX_W-1:0] d, input logic [DP_MAX_W-1:0] e,
                              input int w, input logic sgn);
    logic [DP_MAX_W-1:0] flip;
    flip = (sgn == DP_SIGNED) ? (DP_MAX_W'(1) << (w - 1)) : '0;
    return (d ^ flip) > (e ^ flip);
  endfunction

endpackage

// File: rtl/dp_pipe_stage_reg.sv
// dp_stage_reg: one pipeline stage (valid flag + data word).
//   i_clk, i_rst  clock, synchronous active-high reset (clears valid and data)
//   i_load        stage advances: capture i_data and set valid
//   i_clr         contents consumed downstream: clear valid (load has priority)
//   i_data        incoming data word
//   o_valid       stage holds a live transaction
//   o_data        registered data word, held while i_load is low
module dp_stage_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_load)     r_valid <= 1'b1;
      else if (i_clr) r_valid <= 1'b0;
      if (i_load)     r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dp_pipe.sv
// dp_pipe: two-stage valid/ready datapath.
//   d = a+b, e = a+c, f = a*c  (stage 1)
//   g = d>e, z = max(d,e), x = f - ext(d)  (stage 2, drives outputs)
// Parameters: WIDTH operand width, SIGNED 0 unsigned / 1 two's-complement.
// Ports:
//   Clk, Rst              clock, synchronous active-high reset
//   in_valid, in_ready    operand handshake; in_ready is combinational from out_ready
//   a, b, c               WIDTH-bit operands
//   out_valid, out_ready  result handshake
//   z (WIDTH), g (1), x (2*WIDTH)  results, stable while stalled
module dp_pipe
  import dp_pkg::*;
#(
  parameter int   WIDTH  = 8,
  parameter logic SIGNED = DP_UNSIGNED
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     z,
  output logic                 g,
  output logic [2*WIDTH-1:0]   x
);

  localparam int PW  = prod_w(WIDTH);
  localparam int S1W = 2*WIDTH + PW;
  localparam int S2W = 1 + WIDTH + PW;

  logic           w_adv1;
  logic           w_adv2;
  logic           w_out_xfer;
  logic           w_vld_p1;
  logic           w_vld_p2;

  // ---- stage 0 -> 1: add, add, multiply ----
  logic           w_sa_p0;
  logic           w_sc_p0;
  logic signed [PW-1:0] w_ax_p0;
  logic signed [PW-1:0] w_cx_p0;
  logic [WIDTH-1:0] w_d_p0;
  logic [WIDTH-1:0] w_e_p0;
  logic [PW-1:0]    w_f_p0;
  logic [S1W-1:0]   w_data_p1;

  // Extending both operands to PW bits makes one PW-bit multiply serve both modes.
  assign w_sa_p0 = (SIGNED == DP_SIGNED) ? a[WIDTH-1] : 1'b0;
  assign w_sc_p0 = (SIGNED == DP_SIGNED) ? c[WIDTH-1] : 1'b0;
  assign w_ax_p0 = {{WIDTH{w_sa_p0}}, a};
  assign w_cx_p0 = {{WIDTH{w_sc_p0}}, c};
  assign w_d_p0  = a + b;
  assign w_e_p0  = a + c;
  assign w_f_p0  = w_ax_p0 * w_cx_p0;

  dp_stage_reg #(.WIDTH(S1W)) u_s1 (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_load  (w_adv1),
    .i_clr   (w_adv2),
    .i_data  ({w_d_p0, w_e_p0, w_f_p0}),
    .o_valid (w_vld_p1),
    .o_data  (w_data_p1)
  );

  // ---- stage 1 -> 2: compare, select, subtract ----
  logic [WIDTH-1:0] w_d_p1;
  logic [WIDTH-1:0] w_e_p1;
  logic [PW-1:0]    w_f_p1;
  logic             w_g_p1;
  logic [WIDTH-1:0] w_z_p1;
  logic [PW-1:0]    w_dx_p1;
  logic [PW-1:0]    w_x_p1;
  logic [S2W-1:0]   w_data_p2;

  assign {w_d_p1, w_e_p1, w_f_p1} = w_data_p1;
  assign w_g_p1  = gt(DP_MAX_W'(w_d_p1), DP_MAX_W'(w_e_p1), WIDTH, SIGNED);
  assign w_z_p1  = w_g_p1 ? w_d_p1 : w_e_p1;
  assign w_dx_p1 = PW'(ext_d(DP_MAX_W'(w_d_p1), WIDTH, SIGNED));
  assign w_x_p1  = w_f_p1 - w_dx_p1;

  dp_stage_reg #(.WIDTH(S2W)) u_s2 (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_load  (w_adv2),
    .i_clr   (w_out_xfer),
    .i_data  ({w_g_p1, w_z_p1, w_x_p1}),
    .o_valid (w_vld_p2),
    .o_data  (w_data_p2)
  );

  // ---- handshake ----
  // Stage 2 may refill in the same edge it is drained, so in_ready sees out_ready directly.
  assign w_out_xfer = w_vld_p2 && out_ready;
  assign w_adv2     = w_vld_p1 && (!w_vld_p2 || out_ready);
  assign in_ready   = !w_vld_p1 || w_adv2;
  assign w_adv1     = in_valid && in_ready;

  assign out_valid    = w_vld_p2;
  assign {g, z, x}    = w_data_p2;

endmodule
